fib_run_ctrl: RTL and testbench
===============================

// Module: fib_run_ctrl
// PURPOSE
//  Run sequencer for the Fibonacci generator. Sits between the Wishbone register
//  block (switch, clock_op, irq_out) and the generator datapath.
//  - Clears the generator, then issues rate-divided step pulses until a target
//    step count is reached, a stop is requested, or the value overflows.
//  - Raises sticky per-cause interrupts.
// PARAMETERS
//  CLOCK_WIDTH  6   width of clock_op_i (step period, in wb_clk_i cycles)
//  COUNT_WIDTH  16  width of step counter and target
//  VALUE_WIDTH  30  width of generator value (MSB = overflow sentinel)
// PORTS
//  wb_clk_i     in   1            clock
//  reset        in   1            synchronous, active-high reset
//  enable_i     in   1            global switch; low pauses RUN
//  clock_op_i   in   CLOCK_WIDTH  step period; 0 treated as 1
//  start_i      in   1            1-cycle start pulse
//  stop_i       in   1            1-cycle abort pulse
//  target_i     in   COUNT_WIDTH  steps to run; sampled in CLEAR
//  value_i      in   VALUE_WIDTH  current generator value
//  irq_clr_i    in   3            write-1-to-clear for irq_o
//  step_o       out  1            registered 1-cycle advance strobe to datapath
//  fib_clr_o    out  1            registered 1-cycle generator clear
//  busy_o       out  1            state is CLEAR or RUN
//  steps_o      out  COUNT_WIDTH  steps issued this run
//  snapshot_o   out  VALUE_WIDTH  captured final value (see CONFIGURATION)
//  irq_o        out  3            [0] done, [1] stopped, [2] overflow; sticky
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; div_cnt=0; target_q=0.
//  - States: IDLE, CLEAR, RUN, DONE, HALT. Encoding is in the package.
//  - IDLE -> CLEAR on start_i.
//    CLEAR lasts 1 cycle: fib_clr_o=1 next cycle, steps_o<=0, div_cnt<=0,
//    target_q<=target_i.
//  - CLEAR -> DONE if target_q==0 (no steps issued); else -> RUN.
//  - RUN, enable_i=1, period P=max(clock_op_i,1):
//    - if div_cnt>=P-1: step_o<=1, div_cnt<=0, steps_o<=steps_o+1
//    - else div_cnt<=div_cnt+1
//    - First step_o is asserted P cycles after RUN entry.
//    - clock_op_i changes apply immediately. The >= compare fires on the next
//      cycle if the period shrank below div_cnt.
//  - RUN, enable_i=0: div_cnt and steps_o hold, step_o=0. A pending step is not
//    lost, only delayed.
//  - RUN -> DONE when a step makes steps_o==target_q; irq_o[0] set.
//  - RUN -> HALT when value_i[VALUE_WIDTH-1]==1; irq_o[2] set. Overflow takes
//    priority over done in the same cycle.
//  - stop_i in CLEAR/RUN -> IDLE, irq_o[1] set, steps_o held.
//    stop_i in IDLE/DONE/HALT is ignored.
//  - start_i in CLEAR/RUN is ignored. start_i in DONE/HALT -> CLEAR (restart).
//    Simultaneous start_i and stop_i: stop wins; start is dropped.
//  - steps_o saturates at all-ones: no wrap, no further step_o.
//  - irq_o: bit set takes priority over same-cycle irq_clr_i. Cleared only by
//    irq_clr_i or reset, never by state change.
//  - Reset mid-run: all state and outputs return to reset values next cycle;
//    no irq is raised.
// CONFIGURATION
//  FIB_SNAPSHOT_EN defined:
//  - snapshot_o <= value_i on the cycle of entry to DONE or HALT.
//  - It holds until the next capture or reset.
//  FIB_SNAPSHOT_EN undefined:
//  - snapshot_o is constant 0 and no capture register exists.
// STRUCTURE
//  - Package fib_pkg: state enum, IRQ_DONE/IRQ_STOP/IRQ_OVF bit indices,
//    DEFAULT_PERIOD=1.
//  - Sub-module fib_step_div: period divider with en/clr/period in and tick out;
//    instantiated once.
// TESTING
//  1. clock_op=3, target=4, start:
//     fib_clr_o at +1; step_o at 3-cycle spacing; 4 steps; irq_o=3'b001; busy_o=0.
//  2. target=0, start:
//     DONE two cycles after start; step_o never asserted; irq_o[0]=1.
//  3. clock_op=2, target=10; enable_i low for 5 cycles mid-run:
//     no step_o during the low window; total steps_o=10 at end.
//  4. value_i MSB rises during RUN, on the same cycle as the final step:
//     HALT, irq_o=3'b100; with FIB_SNAPSHOT_EN, snapshot_o==value_i.
//  5. start and stop together in RUN:
//     -> IDLE, irq_o[1]=1; then irq_clr_i=3'b010 -> irq_o=0.
//  6. reset asserted mid-RUN:
//     next cycle all outputs 0, state IDLE, no irq.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci run sequencer: state encoding,
// interrupt bit positions and the fallback step period.
package fib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_HALT  = 3'd4
  } fib_state_e;

  localparam int IRQ_DONE       = 0;
  localparam int IRQ_STOP       = 1;
  localparam int IRQ_OVF        = 2;
  localparam int DEFAULT_PERIOD = 1;

  function automatic logic [2:0] irq_bit(input int idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/fib_step_div.sv
// Step-rate divider: counts enabled cycles and flags a tick once the count
// reaches period-1. Counter freezes while en is low so a pending tick is kept.
module fib_step_div #(
  parameter int CLOCK_WIDTH = 6
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  input  logic [CLOCK_WIDTH-1:0] period,
  output logic                   tick
);

  localparam logic [CLOCK_WIDTH-1:0] ONE = CLOCK_WIDTH'(1);

  logic [CLOCK_WIDTH-1:0] div_cnt;

  // >= rather than == so a shrinking period fires on the next enabled cycle
  assign tick = en && (div_cnt >= (period - ONE));

  always_ff @(posedge wb_clk_i) begin
    if (reset || clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : (div_cnt + ONE);
    end
  end

endmodule

// File: rtl/fib_run_ctrl.sv
// Run sequencer for the Fibonacci generator: clear, rate-divided stepping,
// sticky per-cause interrupts. Optional final-value capture via FIB_SNAPSHOT_EN.
module fib_run_ctrl
  import fib_pkg::*;
#(
  parameter int CLOCK_WIDTH = 6,
  parameter int COUNT_WIDTH = 16,
  parameter int VALUE_WIDTH = 30
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   enable_i,
  input  logic [CLOCK_WIDTH-1:0] clock_op_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [COUNT_WIDTH-1:0] target_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  input  logic [2:0]             irq_clr_i,
  output logic                   step_o,
  output logic                   fib_clr_o,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] steps_o,
  output logic [VALUE_WIDTH-1:0] snapshot_o,
  output logic [2:0]             irq_o
);

  fib_state_e             state_q;
  logic [COUNT_WIDTH-1:0] target_q;
  logic [COUNT_WIDTH-1:0] steps_inc;
  logic [CLOCK_WIDTH-1:0] period;
  logic                   div_tick;
  logic                   div_en;
  logic                   overflow;
  logic                   capture;
  logic [2:0]             irq_kept;

  assign overflow  = value_i[VALUE_WIDTH-1];
  assign steps_inc = steps_o + COUNT_WIDTH'(1);
  assign period    = (clock_op_i == '0) ? CLOCK_WIDTH'(DEFAULT_PERIOD) : clock_op_i;
  assign busy_o    = (state_q == ST_CLEAR) || (state_q == ST_RUN);
  assign irq_kept  = irq_o & ~irq_clr_i;

  // Saturated counter stops the divider, so no step can be issued past all-ones
  assign div_en = (state_q == ST_RUN) && enable_i && (steps_o != '1);

  fib_step_div #(
    .CLOCK_WIDTH(CLOCK_WIDTH)
  ) u_div (
    .wb_clk_i(wb_clk_i),
    .reset   (reset),
    .en      (div_en),
    .clr     (state_q == ST_CLEAR),
    .period  (period),
    .tick    (div_tick)
  );

  // High exactly on the edge that enters DONE or HALT
  assign capture = !stop_i &&
                   (((state_q == ST_CLEAR) && (target_i == '0)) ||
                    ((state_q == ST_RUN) && (overflow || (div_tick && (steps_inc == target_q)))));

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      step_o    <= 1'b0;
      fib_clr_o <= 1'b0;
      steps_o   <= '0;
      target_q  <= '0;
      irq_o     <= '0;
    end else begin
      step_o    <= 1'b0;
      fib_clr_o <= 1'b0;
      irq_o     <= irq_kept;
      case (state_q)
        ST_IDLE, ST_DONE, ST_HALT: begin
          if (start_i && !stop_i) begin
            state_q   <= ST_CLEAR;
            fib_clr_o <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            irq_o   <= irq_kept | irq_bit(IRQ_STOP);
          end else begin
            steps_o  <= '0;
            target_q <= target_i;
            if (target_i == '0) begin
              state_q <= ST_DONE;
              irq_o   <= irq_kept | irq_bit(IRQ_DONE);
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Priority: stop, then overflow, then the regular step/done path
          if (stop_i) begin
            state_q <= ST_IDLE;
            irq_o   <= irq_kept | irq_bit(IRQ_STOP);
          end else if (overflow) begin
            state_q <= ST_HALT;
            irq_o   <= irq_kept | irq_bit(IRQ_OVF);
          end else if (div_tick) begin
            step_o  <= 1'b1;
            steps_o <= steps_inc;
            if (steps_inc == target_q) begin
              state_q <= ST_DONE;
              irq_o   <= irq_kept | irq_bit(IRQ_DONE);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FIB_SNAPSHOT_EN
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      snapshot_o <= '0;
    end else if (capture) begin
      snapshot_o <= value_i;
    end
  end
`else
  logic unused_snapshot;
  assign unused_snapshot = capture ^ (^value_i[VALUE_WIDTH-2:0]);
  assign snapshot_o      = '0;
`endif

endmodule

// File: tb/tb_fib_run_ctrl.sv
// Bench for fib_run_ctrl: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural run model.
module tb_fib_run_ctrl;

  localparam int CW = 6;
  localparam int NW = 16;
  localparam int VW = 30;

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;
  localparam int M_HALT  = 4;

  logic          wb_clk_i = 1'b0;
  logic          reset;
  logic          enable_i;
  logic [CW-1:0] clock_op_i;
  logic          start_i;
  logic          stop_i;
  logic [NW-1:0] target_i;
  logic [VW-1:0] value_i;
  logic [2:0]    irq_clr_i;
  logic          step_o;
  logic          fib_clr_o;
  logic          busy_o;
  logic [NW-1:0] steps_o;
  logic [VW-1:0] snapshot_o;
  logic [2:0]    irq_o;

  fib_run_ctrl #(.CLOCK_WIDTH(CW), .COUNT_WIDTH(NW), .VALUE_WIDTH(VW)) dut (
    .wb_clk_i  (wb_clk_i),
    .reset     (reset),
    .enable_i  (enable_i),
    .clock_op_i(clock_op_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .target_i  (target_i),
    .value_i   (value_i),
    .irq_clr_i (irq_clr_i),
    .step_o    (step_o),
    .fib_clr_o (fib_clr_o),
    .busy_o    (busy_o),
    .steps_o   (steps_o),
    .snapshot_o(snapshot_o),
    .irq_o     (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: run phase, elapsed enabled cycles, steps issued
  int          m_mode = M_IDLE;
  int          m_elapsed = 0;
  int          m_steps = 0;
  int          m_target = 0;
  logic [2:0]  m_irq = '0;
  logic [VW-1:0] m_snap = '0;
  bit          m_step = 0;
  bit          m_clr = 0;

  always @(posedge wb_clk_i) begin : model
    int p;
    logic [2:0] set;
    cyc++;
    set = 3'b000;
    if (reset) begin
      m_mode = M_IDLE; m_elapsed = 0; m_steps = 0; m_target = 0;
      m_irq = '0; m_snap = '0; m_step = 0; m_clr = 0;
    end else begin
      p = (clock_op_i == 0) ? 1 : int'(clock_op_i);
      m_step = 0;
      m_clr  = 0;
      case (m_mode)
        M_CLEAR: begin
          if (stop_i) begin
            m_mode = M_IDLE; set[1] = 1'b1;
          end else begin
            m_steps = 0; m_elapsed = 0; m_target = int'(target_i);
            if (m_target == 0) begin
              m_mode = M_DONE; set[0] = 1'b1; m_snap = value_i;
            end else m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (stop_i) begin
            m_mode = M_IDLE; set[1] = 1'b1;
          end else if (value_i[VW-1]) begin
            m_mode = M_HALT; set[2] = 1'b1; m_snap = value_i;
          end else if (enable_i && m_steps < 65535) begin
            if (m_elapsed + 1 >= p) begin
              m_step = 1; m_elapsed = 0; m_steps++;
              if (m_steps == m_target) begin
                m_mode = M_DONE; set[0] = 1'b1; m_snap = value_i;
              end
            end else m_elapsed++;
          end
        end
        default: begin
          if (start_i && !stop_i) begin
            m_mode = M_CLEAR; m_clr = 1;
          end
        end
      endcase
      m_irq = (m_irq & ~irq_clr_i) | set;
    end
    #1;
    chk("step_o", step_o, m_step);
    chk("fib_clr_o", fib_clr_o, m_clr);
    chk("busy_o", busy_o, (m_mode == M_CLEAR || m_mode == M_RUN));
    chk("steps_o", steps_o, m_steps);
    chk("irq_o", irq_o, m_irq);
`ifdef FIB_SNAPSHOT_EN
    chk("snapshot_o", snapshot_o, m_snap);
`else
    chk("snapshot_o", snapshot_o, 0);
`endif
  end

  task automatic do_reset();
    reset = 1; start_i = 0; stop_i = 0; irq_clr_i = 0; enable_i = 1; value_i = '0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    reset = 0;
  endtask

  task automatic pulse_start();
    @(negedge wb_clk_i);
    start_i = 1;
    @(negedge wb_clk_i);
    start_i = 0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (!busy_o) return;
      @(negedge wb_clk_i);
    end
    chk(name, busy_o, 0);
  endtask

  task automatic wait_steps(input int n, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (int'(steps_o) >= n) return;
      @(negedge wb_clk_i);
    end
    chk(name, steps_o, n);
  endtask

  initial begin
    int ns;
    int last_c;
    logic [NW-1:0] held;
    logic [VW-1:0] ovf_val;

    reset = 1; enable_i = 1; start_i = 0; stop_i = 0; clock_op_i = 6'd3;
    target_i = 16'd4; value_i = '0; irq_clr_i = 3'b000;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_step", step_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_steps", steps_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_clr", fib_clr_o, 0);
    reset = 0;

    // Period 3, four steps
    pulse_start();
    chk("t1_fib_clr", fib_clr_o, 1);
    ns = 0; last_c = 0;
    for (int k = 0; k < 60; k++) begin
      if (step_o) begin
        if (ns > 0) chk("t1_spacing", cyc - last_c, 3);
        last_c = cyc;
        ns++;
      end
      if (!busy_o) break;
      @(negedge wb_clk_i);
    end
    chk("t1_nsteps", ns, 4);
    chk("t1_steps_o", steps_o, 4);
    chk("t1_irq", irq_o, 3'b001);
    chk("t1_busy", busy_o, 0);

    // Zero target finishes without stepping
    do_reset();
    target_i = 16'd0;
    pulse_start();
    @(negedge wb_clk_i);
    chk("t2_busy", busy_o, 0);
    chk("t2_irq", irq_o, 3'b001);
    chk("t2_steps", steps_o, 0);

    // Enable dropped mid-run
    do_reset();
    clock_op_i = 6'd2; target_i = 16'd10;
    pulse_start();
    wait_steps(3, 40, "t3_wait_steps");
    enable_i = 0;
    held = steps_o;
    for (int k = 0; k < 5; k++) begin
      @(negedge wb_clk_i);
      chk("t3_no_step", step_o, 0);
    end
    chk("t3_held", steps_o, held);
    enable_i = 1;
    wait_idle(80, "t3_timeout");
    chk("t3_steps", steps_o, 10);
    chk("t3_irq", irq_o, 3'b001);

    // Overflow on the cycle the final step would fire
    do_reset();
    clock_op_i = 6'd1; target_i = 16'd3;
    pulse_start();
    wait_steps(2, 20, "t4_wait_steps");
    ovf_val = {1'b1, 29'h0ABCDE1};
    value_i = ovf_val;
    @(negedge wb_clk_i);
    value_i = '0;
    chk("t4_irq", irq_o, 3'b100);
    chk("t4_busy", busy_o, 0);
    chk("t4_steps", steps_o, 2);
`ifdef FIB_SNAPSHOT_EN
    chk("t4_snapshot", snapshot_o, ovf_val);
`else
    chk("t4_snapshot", snapshot_o, 0);
`endif

    // Start and stop together during a run
    do_reset();
    clock_op_i = 6'd1; target_i = 16'd50;
    pulse_start();
    repeat (4) @(negedge wb_clk_i);
    start_i = 1; stop_i = 1;
    @(negedge wb_clk_i);
    start_i = 0; stop_i = 0;
    chk("t5_busy", busy_o, 0);
    chk("t5_irq", irq_o, 3'b010);
    irq_clr_i = 3'b010;
    @(negedge wb_clk_i);
    irq_clr_i = 3'b000;
    chk("t5_irq_clr", irq_o, 3'b000);

    // Reset in the middle of a run
    do_reset();
    clock_op_i = 6'd2; target_i = 16'd50;
    pulse_start();
    repeat (6) @(negedge wb_clk_i);
    reset = 1;
    @(negedge wb_clk_i);
    chk("t6_step", step_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_steps", steps_o, 0);
    chk("t6_irq", irq_o, 0);
    chk("t6_clr", fib_clr_o, 0);
    chk("t6_snap", snapshot_o, 0);
    reset = 0;

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      @(negedge wb_clk_i);
      reset    = ($urandom_range(0, 599) == 0);
      enable_i = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 29) == 0) clock_op_i = 6'($urandom_range(0, 5));
      start_i  = ($urandom_range(0, 14) == 0);
      stop_i   = ($urandom_range(0, 59) == 0);
      target_i = 16'($urandom_range(0, 8));
      value_i  = {($urandom_range(0, 199) == 0), 29'($urandom)};
      irq_clr_i = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
    end
    @(negedge wb_clk_i);
    reset = 0; start_i = 0; stop_i = 0;
    @(negedge wb_clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
